// File: rtl/cpu_run_controller.sv
// cpu_run_controller: owns the core's RST_N/HALT pins and sequences reset,
// slow run, fast run and single-step execution from board switches/buttons.
// Optional feature macro: CPU_CTRL_DEBOUNCE_EN (counter-based button debouncer).
module cpu_run_controller #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        RST_N,
    input  logic        soft_rst,
    input  logic        run_en,
    input  logic        fast_en,
    input  logic        step_btn,
    input  logic        halt_btn,
    output logic        cpu_rst_n,
    output logic        cpu_halt,
    output logic [15:0] step_count,
    output logic [1:0]  state
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be >= 2");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset
        $error("RESET_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        HALTED     = 2'd1,
        RUN        = 2'd2,
        STEP       = 2'd3
    } state_t;

    state_t            cur;
    state_t            nxt;
    logic [1:0]        step_sync;
    logic [1:0]        halt_sync;
    logic              step_lvl;
    logic              halt_c;
    logic              step_prev;
    logic              step_pulse;
    logic [RST_W-1:0]  rst_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              halt_nxt;
    logic              rst_n_nxt;

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            step_sync <= 2'b00;
            halt_sync <= 2'b00;
        end else begin
            step_sync <= {step_sync[0], step_btn};
            halt_sync <= {halt_sync[0], halt_btn};
        end
    end

`ifdef CPU_CTRL_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] step_db_cnt;
    logic [DB_W-1:0] halt_db_cnt;
    logic            halt_lvl;

    // Accept a new level only after it has persisted; any bounce restarts the count
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            step_db_cnt <= '0;
            halt_db_cnt <= '0;
            step_lvl    <= 1'b0;
            halt_lvl    <= 1'b0;
        end else begin
            if (step_sync[1] == step_lvl) begin
                step_db_cnt <= '0;
            end else if (step_db_cnt == DB_LAST) begin
                step_lvl    <= step_sync[1];
                step_db_cnt <= '0;
            end else begin
                step_db_cnt <= step_db_cnt + DB_W'(1);
            end

            if (halt_sync[1] == halt_lvl) begin
                halt_db_cnt <= '0;
            end else if (halt_db_cnt == DB_LAST) begin
                halt_lvl    <= halt_sync[1];
                halt_db_cnt <= '0;
            end else begin
                halt_db_cnt <= halt_db_cnt + DB_W'(1);
            end
        end
    end

    assign halt_c = halt_lvl;
`else
    // Without the debouncer the synchronized levels are used directly
    assign step_lvl = step_sync[1];
    assign halt_c   = halt_sync[1];
`endif

    // Registered rising-edge detector: one step_pulse per button press
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            step_prev  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_prev  <= step_lvl;
            step_pulse <= step_lvl & ~step_prev;
        end
    end

    // FSM state register
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            cur <= RESET_HOLD;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state and next-output decode; soft_rst overrides every transition
    always_comb begin
        nxt       = cur;
        halt_nxt  = 1'b1;
        rst_n_nxt = 1'b1;

        case (cur)
            RESET_HOLD: if (rst_cnt == RST_LAST) nxt = HALTED;
            HALTED: begin
                if (run_en && !halt_c) begin
                    nxt = RUN;
                end else if (!run_en && !halt_c && step_pulse) begin
                    nxt = STEP;
                end
            end
            RUN:     if (!run_en) nxt = HALTED;
            STEP:    nxt = HALTED;
            default: nxt = RESET_HOLD;
        endcase

        if (soft_rst) begin
            nxt = RESET_HOLD;
        end

        if (nxt == STEP) begin
            halt_nxt = 1'b0;
        end else if (nxt == RUN && !halt_c && (fast_en || tick_cnt == TICK_LAST)) begin
            halt_nxt = 1'b0;
        end

        rst_n_nxt = (nxt != RESET_HOLD);
    end

    // Reset-hold and slow-run tick counters; the tick counter idles at zero outside RUN
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            rst_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            if (soft_rst || cur != RESET_HOLD || rst_cnt == RST_LAST) begin
                rst_cnt <= '0;
            end else begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end

            if (soft_rst || cur != RUN) begin
                tick_cnt <= '0;
            end else if (!fast_en && !halt_c) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
            end
        end
    end

    // Registered core controls and enabled-cycle counter
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            cpu_rst_n  <= 1'b0;
            cpu_halt   <= 1'b1;
            step_count <= 16'd0;
        end else begin
            cpu_rst_n <= rst_n_nxt;
            cpu_halt  <= halt_nxt;
            if (soft_rst) begin
                step_count <= 16'd0;
            end else if (cpu_rst_n && !cpu_halt) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: each operation predicts the exact
// cycles on which the core should be enabled; a monitor matches enabled cycles.
module tb_cpu_run_controller;

    localparam int unsigned TICK_DIV        = 4;
    localparam int unsigned RESET_CYCLES    = 3;
    localparam int unsigned DEBOUNCE_CYCLES = 5;

    // Latency from the driving negedge to the enabled cycle of a step press
    localparam int unsigned STEP_LAT = 4;
    // Edges between halt_btn change and the edge where cpu_halt reacts
    localparam int unsigned HALT_LAT = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        soft_rst = 1'b0;
    logic        run_en   = 1'b0;
    logic        fast_en  = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_btn = 1'b0;
    logic        cpu_rst_n;
    logic        cpu_halt;
    logic [15:0] step_count;
    logic [1:0]  state;

    cpu_run_controller #(
        .TICK_DIV        (TICK_DIV),
        .RESET_CYCLES    (RESET_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .CLK100MHZ  (clk),
        .RST_N      (rst_n),
        .soft_rst   (soft_rst),
        .run_en     (run_en),
        .fast_en    (fast_en),
        .step_btn   (step_btn),
        .halt_btn   (halt_btn),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_halt   (cpu_halt),
        .step_count (step_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        int unsigned st;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc         = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned n_en        = 0;

    // Count active edges so expectations can be stated as absolute cycle numbers
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_enable(input int unsigned c, input int unsigned st);
        exp_q.push_back('{cyc: c, cnt: n_en, st: st});
        n_en++;
    endtask

    // Monitor: every enabled core cycle must match the next predicted one
    always @(negedge clk) begin
        if (cpu_rst_n === 1'b1 && cpu_halt === 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_enable: enabled cycle at %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("enable_cycle", cyc, mon_e.cyc);
                check("enable_count", 32'(step_count), mon_e.cnt);
                check("enable_state", 32'(state), mon_e.st);
            end
        end
    end

    // Every prediction consumed and count consistent once the core is idle
    task automatic settle();
        check("pending_enables", exp_q.size(), 0);
        exp_q.delete();
        check("idle_step_count", 32'(step_count), n_en);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
        check({tag, "_cpu_halt"}, 32'(cpu_halt), 1);
        check({tag, "_step_count"}, 32'(step_count), 0);
    endtask

    // After a reset is released: RESET_CYCLES-1 low cycles, then core out of reset but halted
    task automatic check_reset_sequence(input string tag);
        for (int i = 1; i < int'(RESET_CYCLES); i++) begin
            tick(1);
            check({tag, "_hold_rst_n"}, 32'(cpu_rst_n), 0);
        end
        tick(1);
        check({tag, "_rise_rst_n"}, 32'(cpu_rst_n), 1);
        check({tag, "_rise_state"}, 32'(state), 1);
        check({tag, "_rise_halt"}, 32'(cpu_halt), 1);
        check({tag, "_rise_count"}, 32'(step_count), 0);
        n_en = 0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        check_reset_values("por");
        check_reset_sequence("por");
    endtask

    task automatic do_step(input int unsigned hold);
        step_btn = 1'b1;
        expect_enable(cyc + STEP_LAT, 3);
        tick(hold);
        step_btn = 1'b0;
        tick(6);
        settle();
    endtask

    // Slow run for d cycles; optionally press step mid-run (must be ignored)
    task automatic do_slow(input int unsigned d, input bit poke_step);
        int unsigned m;
        m = cyc;
        run_en = 1'b1;
        for (int unsigned t = m + 1 + TICK_DIV; t <= m + d; t += TICK_DIV) expect_enable(t, 2);
        tick(2);
        step_btn = poke_step;
        tick(2);
        step_btn = 1'b0;
        tick(d - 4);
        run_en = 1'b0;
        tick(3);
        check("slow_stop_state", 32'(state), 1);
        settle();
    endtask

    task automatic do_fast(input int unsigned d);
        int unsigned m;
        m = cyc;
        run_en  = 1'b1;
        fast_en = 1'b1;
        for (int unsigned t = m + 1; t <= m + d; t++) expect_enable(t, 2);
        tick(d);
        run_en = 1'b0;
        tick(1);
        fast_en = 1'b0;
        tick(2);
        settle();
    endtask

    task automatic do_fast_halt(input int unsigned dh);
        int unsigned m;
        m = cyc;
        run_en  = 1'b1;
        fast_en = 1'b1;
        for (int unsigned t = m + 1; t < m + dh + HALT_LAT; t++) expect_enable(t, 2);
        tick(dh);
        halt_btn = 1'b1;
        tick(HALT_LAT);
        check("halt_cpu_halt", 32'(cpu_halt), 1);
        check("halt_frozen_count", 32'(step_count), n_en);
        tick(5);
        check("halt_frozen_count2", 32'(step_count), n_en);
        check("halt_state_run", 32'(state), 2);
        run_en = 1'b0;
        tick(2);
        check("halt_state_halted", 32'(state), 1);
        halt_btn = 1'b0;
        tick(4);
        fast_en = 1'b0;
        tick(1);
        settle();
    endtask

    task automatic do_step_while_halt();
        halt_btn = 1'b1;
        tick(4);
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        tick(6);
        check("halted_step_state", 32'(state), 1);
        halt_btn = 1'b0;
        tick(4);
        settle();
    endtask

    // soft_rst for s cycles, optionally with a step press; optional fast run beforehand
    task automatic do_soft(input int unsigned s, input bit with_step, input int unsigned run_d);
        int unsigned m;
        if (run_d != 0) begin
            m = cyc;
            run_en  = 1'b1;
            fast_en = 1'b1;
            for (int unsigned t = m + 1; t <= m + run_d; t++) expect_enable(t, 2);
            tick(run_d);
            run_en  = 1'b0;
            fast_en = 1'b0;
        end
        soft_rst = 1'b1;
        step_btn = with_step;
        tick(1);
        check("soft_state", 32'(state), 0);
        check("soft_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("soft_cpu_halt", 32'(cpu_halt), 1);
        tick(s - 1);
        soft_rst = 1'b0;
        check("soft_pending", exp_q.size(), 0);
        exp_q.delete();
        check_reset_sequence("soft");
        step_btn = 1'b0;
        tick(4);
        settle();
    endtask

    initial begin
        tick(3);
        release_reset();
        tick(2);

        do_step(1);
        do_step(2);
        do_step(1);
        check("three_steps_count", 32'(step_count), 3);
        do_step(20);
        check("held_step_count", 32'(step_count), 4);
        do_slow(40, 1'b0);
        do_fast(10);
        do_fast_halt(6);
        do_step_while_halt();
        do_soft(2, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: do_step($urandom_range(1, 20));
                1: do_slow($urandom_range(8, 40), 1'($urandom_range(0, 1)));
                2: do_fast($urandom_range(1, 30));
                3: do_fast_halt($urandom_range(1, 10));
                4: do_step_while_halt();
                default: do_soft($urandom_range(1, 4), 1'($urandom_range(0, 1)),
                                 $urandom_range(0, 1) * $urandom_range(1, 8));
            endcase
        end

        // Asynchronous reset during the single enabled STEP cycle
        do_step(1);
        step_btn = 1'b1;
        expect_enable(cyc + STEP_LAT, 3);
        tick(1);
        step_btn = 1'b0;
        tick(STEP_LAT - 1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async");
        check("async_pending", exp_q.size(), 0);
        exp_q.delete();
        tick(2);
        release_reset();
        tick(2);
        do_step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequences the bring-up and execution of the RISC-V core on the FPGA debug board. It owns the core's reset and halt inputs and generates them from board-level controls. Three execution modes are supported: free-running at a slow visible rate, full-speed, and single-step on a button press. It sits between the board's switches and buttons and the core's RST_N/HALT pins, and replaces the ad-hoc counter logic in the top-level wrapper.

## Interface
- TICK_DIV, 50_000_000: clock cycles between enabled cycles in slow-run mode (0.5 s at 100 MHz); must be ≥2.
- RESET_CYCLES, 16: cycles cpu_rst_n is held low after any reset; must be ≥1.
- DEBOUNCE_CYCLES, 1_000_000: cycles a button must be stable before the change is accepted (used only with CPU_CTRL_DEBOUNCE_EN).
- CLK100MHZ  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- soft_rst  in  1  synchronous level reset (board switch); 1 = force a reset sequence.
- run_en  in  1  1 = run mode; 0 = step mode.
- fast_en  in  1  in run mode: 1 = enable every cycle; 0 = one enabled cycle per TICK_DIV.
- step_btn  in  1  raw step button, asynchronous.
- halt_btn  in  1  raw halt button, asynchronous; 1 = freeze.
- cpu_rst_n  out  1  to core RST_N.
- cpu_halt  out  1  to core HALT; 0 = core advances this cycle.
- step_count  out  16  count of enabled core cycles since the last reset; wraps.
- state  out  2  current FSM state, for debug LEDs.

## Operation
- Button conditioning:
  - step_btn and halt_btn each pass through a 2-flop synchronizer, then the optional debouncer.
  - step_btn then goes through a registered rising-edge detector that produces step_pulse.
  - The conditioned halt level is called halt_c.
- FSM states and encodings: RESET_HOLD=0, HALTED=1, RUN=2, STEP=3.
  - RESET_HOLD:
    - The reset counter counts 0..RESET_CYCLES-1.
    - At the terminal count the FSM goes to HALTED.
  - HALTED:
    - Goes to RUN if run_en=1 and halt_c=0.
    - Otherwise goes to STEP if run_en=0, halt_c=0 and step_pulse=1.
    - Otherwise stays in HALTED.
  - RUN: goes to HALTED if run_en=0.
  - STEP: always goes to HALTED on the next cycle. This gives exactly one enabled cycle per press.
- Any state goes to RESET_HOLD when soft_rst=1. The reset counter, tick counter and step_count are cleared. soft_rst has top priority.
- Tick counter behaviour:
  - It is $clog2(TICK_DIV) bits wide.
  - It is cleared on entry to RUN.
  - In RUN with fast_en=0 and halt_c=0, it counts 0..TICK_DIV-1 and wraps.
  - It is frozen while halt_c=1.
- cpu_halt:
  - Registered.
  - Next value is 0 when the next state is STEP.
  - Next value is also 0 when the next state is RUN, halt_c=0, and either fast_en=1 or the tick counter is at TICK_DIV-1.
  - Otherwise the next value is 1.
- cpu_rst_n: registered; its next value is 0 iff the next state is RESET_HOLD.
- step_count: increments on each cycle where cpu_rst_n=1 and cpu_halt=0; wraps 0xFFFF→0x0000.
- Priorities:
  - soft_rst > halt_c > step_pulse.
  - A step_pulse in run mode, or while halt_c=1, is discarded and not queued.
  - A step_pulse arriving in STEP is discarded.
- Reset:
  - RST_N=0, even mid-operation or mid-step, immediately forces: state=RESET_HOLD, cpu_rst_n=0, cpu_halt=1, step_count=0, all counters=0, synchronizers=0.
  - After RST_N deasserts, the normal RESET_HOLD sequence runs.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- After RST_N or soft_rst is released, cpu_rst_n rises RESET_CYCLES cycles later. cpu_halt stays 1 at that point.
- Step latency (macro off): the first edge that samples step_btn=1 is edge k. cpu_halt=0 and state=STEP hold for the single cycle after edge k+3.
- Slow run:
  - The first enabled cycle occurs TICK_DIV cycles after entering RUN.
  - After that, there is exactly one enabled cycle every TICK_DIV cycles.
- Fast run: cpu_halt=0 from the cycle after entering RUN, continuously.
- halt_btn: takes effect 2 cycles after it is first sampled (macro off). No enabled cycle is produced after that point.

## Configuration
- CPU_CTRL_DEBOUNCE_EN defined:
  - Each synchronized button feeds a counter-based debouncer.
  - The conditioned level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - This adds DEBOUNCE_CYCLES of latency to both buttons.
- Not defined: the debouncer is removed and the synchronizer output drives the conditioned level directly. DEBOUNCE_CYCLES is then unused.

## Test plan
Parameters for all scenarios: TICK_DIV=4, RESET_CYCLES=3, DEBOUNCE_CYCLES=5.

- Reset: hold RST_N=0 and then release → cpu_rst_n=0 for 3 cycles then 1; cpu_halt=1; state=1; step_count=0.
- Single-step: run_en=0, pulse step_btn three times → exactly 3 single-cycle cpu_halt=0 pulses and step_count=3. Holding step_btn high for 20 cycles yields 1 pulse, not 20.
- Slow run: run_en=1, fast_en=0 for 40 cycles → cpu_halt=0 exactly once every 4 cycles; step_count=10 ±1.
- Halt and priority:
  - fast_en=1, assert halt_btn → cpu_halt=1 within 2 cycles and step_count frozen.
  - soft_rst together with step_btn → state=0 and no enabled cycle.
- Async reset mid-run: drop RST_N during STEP → all outputs take their reset values without a clock edge.
- Debounce (macro on): step_btn toggled every 2 cycles for 20 cycles, then held → exactly one step, occurring 5+3 cycles after the hold begins.
